// File: rtl/sdf_butterfly_stage_pkg.sv
// Shared FFT constants and twiddle helpers for the radix-2 single-path
// delay-feedback butterfly stage.
package sdf_butterfly_stage_pkg;

   localparam int DATA_W = 32;
   localparam int TW_W = 18;
   localparam int TW_FRAC = 16;
   localparam int TW_UNITY_INT = 65536;
   localparam logic signed [TW_W-1:0] TW_UNITY = TW_W'(TW_UNITY_INT);

   localparam real PI = 3.14159265358979323846;

   // Q2.16 quantisation with round half away from zero.
   function automatic logic signed [TW_W-1:0] q16_round(input real v);
      real s;
      int r;
      s = v * (2.0 ** TW_FRAC);
      if (s >= 0.0) r = $rtoi($floor(s + 0.5));
      else r = -$rtoi($floor(-s + 0.5));
      return TW_W'(r);
   endfunction

   function automatic logic signed [TW_W-1:0] tw_re_of(input int k, input int dlog2);
      return q16_round($cos(PI * real'(k) / real'(1 << dlog2)));
   endfunction

   function automatic logic signed [TW_W-1:0] tw_im_of(input int k, input int dlog2);
      return q16_round(-$sin(PI * real'(k) / real'(1 << dlog2)));
   endfunction

endpackage

// File: rtl/sdf_butterfly_stage_twiddle_rom.sv
// Twiddle table W(k) = exp(-j*pi*k/D) with a registered output; the
// unity select substitutes 1.0 for the sum half of each frame.
module twiddle_rom
   import sdf_butterfly_stage_pkg::*;
#(
   parameter int DLOG2 = 2
)
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   en,
   input  logic                   unity,
   input  logic [DLOG2-1:0]       addr,
   output logic signed [TW_W-1:0] tw_re,
   output logic signed [TW_W-1:0] tw_im
);

   localparam int D = 1 << DLOG2;

   logic signed [TW_W-1:0] tab_re [D];
   logic signed [TW_W-1:0] tab_im [D];
   logic signed [TW_W-1:0] tw_re_q, tw_re_d;
   logic signed [TW_W-1:0] tw_im_q, tw_im_d;

   // Entries are elaboration-time constants, so the table folds to logic.
   for (genvar i = 0; i < D; i++) begin : g_tab
      localparam logic signed [TW_W-1:0] ENTRY_RE = tw_re_of(i, DLOG2);
      localparam logic signed [TW_W-1:0] ENTRY_IM = tw_im_of(i, DLOG2);
      assign tab_re[i] = ENTRY_RE;
      assign tab_im[i] = ENTRY_IM;
   end

   always_comb begin
      tw_re_d = tw_re_q;
      tw_im_d = tw_im_q;
      if (en) begin
         if (unity) begin
            tw_re_d = TW_UNITY;
            tw_im_d = '0;
         end else begin
            tw_re_d = tab_re[addr];
            tw_im_d = tab_im[addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tw_re_q <= TW_UNITY;
         tw_im_q <= '0;
      end else begin
         tw_re_q <= tw_re_d;
         tw_im_q <= tw_im_d;
      end
   end

   assign tw_re = tw_re_q;
   assign tw_im = tw_im_q;

endmodule

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 SDF butterfly stage: the first half of each frame is parked in a
// D-entry buffer, the second half emits halved sums and parks halved
// differences, which stream out with W(k) during the next frame's first half.
module sdf_butterfly_stage
   import sdf_butterfly_stage_pkg::*;
#(
   parameter int DLOG2 = 2
)
(
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_re,
   output logic signed [DATA_W-1:0] out_im,
   output logic signed [TW_W-1:0]   tw_re,
   output logic signed [TW_W-1:0]   tw_im,
   output logic                     out_sof
);

   localparam int D = 1 << DLOG2;

   logic [DLOG2:0]            cnt_q, cnt_d;
   logic                      primed_q, primed_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_sof_q, out_sof_d;
   logic signed [DATA_W-1:0]  out_re_q, out_re_d;
   logic signed [DATA_W-1:0]  out_im_q, out_im_d;

   logic signed [DATA_W-1:0]  buf_re_q [D];
   logic signed [DATA_W-1:0]  buf_im_q [D];
   logic                      buf_we;
   logic signed [DATA_W-1:0]  buf_wr_re, buf_wr_im;

   logic                      phase;
   logic [DLOG2-1:0]          k;
   logic signed [DATA_W-1:0]  y_re, y_im;
   logic signed [DATA_W:0]    sum_re, sum_im, diff_re, diff_im;
   logic                      tw_en;

   // One extra bit of headroom makes the halved sum/difference exact in 32 bits.
   always_comb begin
      phase   = cnt_q[DLOG2];
      k       = cnt_q[DLOG2-1:0];
      y_re    = buf_re_q[k];
      y_im    = buf_im_q[k];
      sum_re  = {y_re[DATA_W-1], y_re} + {in_re[DATA_W-1], in_re};
      sum_im  = {y_im[DATA_W-1], y_im} + {in_im[DATA_W-1], in_im};
      diff_re = {y_re[DATA_W-1], y_re} - {in_re[DATA_W-1], in_re};
      diff_im = {y_im[DATA_W-1], y_im} - {in_im[DATA_W-1], in_im};

      cnt_d       = cnt_q;
      primed_d    = primed_q;
      out_valid_d = 1'b0;
      out_sof_d   = 1'b0;
      out_re_d    = out_re_q;
      out_im_d    = out_im_q;
      buf_we      = 1'b0;
      buf_wr_re   = in_re;
      buf_wr_im   = in_im;

      if (in_valid) begin
         cnt_d  = cnt_q + 1'b1;
         buf_we = 1'b1;
         if (!phase) begin
            out_valid_d = primed_q;
            if (primed_q) begin
               out_re_d = y_re;
               out_im_d = y_im;
            end
         end else begin
            primed_d    = 1'b1;
            out_valid_d = 1'b1;
            out_sof_d   = (k == '0);
            out_re_d    = DATA_W'(sum_re >>> 1);
            out_im_d    = DATA_W'(sum_im >>> 1);
            buf_wr_re   = DATA_W'(diff_re >>> 1);
            buf_wr_im   = DATA_W'(diff_im >>> 1);
         end
      end

      tw_en = out_valid_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q       <= '0;
         primed_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_re_q    <= '0;
         out_im_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         primed_q    <= primed_d;
         out_valid_q <= out_valid_d;
         out_sof_q   <= out_sof_d;
         out_re_q    <= out_re_d;
         out_im_q    <= out_im_d;
      end
   end

   // Stale buffer contents after reset are hidden by primed_q.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_re_q[k] <= buf_wr_re;
         buf_im_q[k] <= buf_wr_im;
      end
   end

   twiddle_rom #(
      .DLOG2 (DLOG2)
   ) u_twiddle_rom (
      .clk   (clk),
      .rstn  (rstn),
      .en    (tw_en),
      .unity (phase),
      .addr  (k),
      .tw_re (tw_re),
      .tw_im (tw_im)
   );

   assign out_valid = out_valid_q;
   assign out_sof   = out_sof_q;
   assign out_re    = out_re_q;
   assign out_im    = out_im_q;

endmodule

// File: doc/sdf_butterfly_stage.md
SDF_BUTTERFLY_STAGE -- requirements
Module: sdf_butterfly_stage

Interface
REQ-001 Parameter DLOG2, default 2, log2 of delay-buffer depth D = 2^DLOG2; legal range 1..10.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rstn  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies in_re/in_im this cycle.
REQ-005 in_re, in_im  input  32 each  signed two's-complement complex sample.
REQ-006 out_valid  output  1  qualifies out_re/out_im/tw_re/tw_im.
REQ-007 out_re, out_im  output  32 each  signed butterfly result; drive the downstream complex multiplier a/b ports.
REQ-008 tw_re, tw_im  output  18 each  signed twiddle, Q2.16 (1.0 = 65536); drive the multiplier c/d ports.
REQ-009 out_sof  output  1  high with the first sum output of each frame.

Function
REQ-010 A frame is 2D accepted samples; accepted = in_valid high at a rising edge; cycles with in_valid low do not advance any state.
REQ-011 A (DLOG2+1)-bit sample counter cnt increments per accepted sample and wraps 2D-1 -> 0; k = cnt[DLOG2-1:0].
REQ-012 Phase 0 (cnt MSB = 0): sample written to buffer slot k; output = buffered difference from slot k, twiddle W(k).
REQ-013 Phase 1 (cnt MSB = 1): with y = buffer slot k, x = input: output = (y + x) >>> 1, twiddle = 1.0 (tw_re 65536, tw_im 0); slot k overwritten with (y - x) >>> 1.
REQ-014 Sum/difference computed at 33 bits, arithmetic shift right by 1, truncated to 32 bits; never overflows, no saturation logic.
REQ-015 W(k) = exp(-j*pi*k/D): tw_re = round(cos(pi*k/D)*65536), tw_im = round(-sin(pi*k/D)*65536), round half away from zero.
REQ-016 All outputs registered; latency exactly 1 cycle from accepting edge to output edge.
REQ-017 out_valid high the cycle after every phase-1 acceptance, and after a phase-0 acceptance only when primed = 1.
REQ-018 primed set on the first phase-1 acceptance after reset, cleared only by reset; no spurious outputs in the first phase 0.
REQ-019 out_valid low whenever no sample was accepted the previous cycle; out_re/out_im/tw_* hold their last value then.
REQ-020 Differences of the final frame drain only as the next frame's phase-0 samples arrive; upstream appends a zero frame to flush.
REQ-021 out_sof high only alongside out_valid for k = 0 in phase 1.

Reset
REQ-022 rstn low asynchronously clears cnt, primed, out_valid, out_sof, out_re, out_im, tw_im to 0 and sets tw_re to 65536.
REQ-023 Buffer contents not reset; primed = 0 masks them.
REQ-024 Reset mid-frame abandons the partial frame; the first accepted sample after release is frame sample 0.

Structure
REQ-025 Shared FFT package holds data width 32, twiddle width 18, twiddle fraction bits 16, unity constant 65536.
REQ-026 One sub-module twiddle_rom: combinational-address, registered-output table of D entries indexed by k, entries generated per REQ-015.
REQ-027 Delay buffer is a D-entry register array or inferred RAM indexed by k; no separate FIFO pointers.

Verification (DLOG2 = 2, D = 4)
REQ-028 Frame in_re = 1..8, in_im = 0, in_valid continuous -> phase-1 outputs out_re 3,4,5,6, tw 65536/0, out_sof on first; no out_valid during first four cycles.
REQ-029 Zero frame follows -> four outputs out_re -2 each with (tw_re,tw_im) = (65536,0),(46341,-46341),(0,-65536),(-46341,-46341), then four sums 0.
REQ-030 Extremes: y = x = 0x7FFFFFFF -> sum 0x7FFFFFFF, diff 0; y = x = 0x80000000 -> sum 0x80000000; y = 0x7FFFFFFF, x = 0x80000000 -> diff 0x7FFFFFFF.
REQ-031 Same frame as REQ-028 with in_valid toggled every other cycle -> identical output sequence, each out_valid exactly 1 cycle after its acceptance.
REQ-032 Assert rstn low after 5 samples, then replay REQ-028 -> outputs match REQ-028 exactly, tw_re 65536 during reset.
REQ-033 Odd sums: y = 1, x = 2 -> sum 1, diff -1 (arithmetic shift truncates toward minus infinity).
